// File: rtl/usb_desc_pkg.sv
// Shared constants and types for the USB descriptor builder.
// USB_DESC_HID_EN adds a HID class descriptor to the configuration.
package usb_desc_pkg;

  localparam logic [7:0] DESC_DEVICE        = 8'h01;
  localparam logic [7:0] DESC_CONFIGURATION = 8'h02;
  localparam logic [7:0] DESC_INTERFACE     = 8'h04;
  localparam logic [7:0] DESC_ENDPOINT      = 8'h05;
  localparam logic [7:0] DESC_HID           = 8'h21;

  localparam logic [1:0] XFER_CONTROL     = 2'd0;
  localparam logic [1:0] XFER_ISOCHRONOUS = 2'd1;
  localparam logic [1:0] XFER_BULK        = 2'd2;
  localparam logic [1:0] XFER_INTERRUPT   = 2'd3;

  localparam logic [5:0] DEV_LEN = 6'd18;
  localparam logic [5:0] CFG_LEN = 6'd9;
  localparam logic [5:0] IF_LEN  = 6'd9;
  localparam logic [5:0] HID_LEN = 6'd9;
  localparam logic [5:0] EP_LEN  = 6'd7;

  localparam logic [5:0] IF_END = CFG_LEN + IF_LEN;
`ifdef USB_DESC_HID_EN
  localparam logic [5:0] EP_BASE = IF_END + HID_LEN;
`else
  localparam logic [5:0] EP_BASE = IF_END;
`endif
  localparam logic [5:0] CFG_TOTAL = EP_BASE + EP_LEN;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  function automatic logic is_std_desc(input logic [7:0] t);
    return (t == DESC_DEVICE) || (t == DESC_CONFIGURATION);
  endfunction

endpackage

// File: rtl/usb_desc_rom.sv
// Combinational descriptor byte mux: (type, index, fields) -> byte.
// USB_DESC_HID_EN inserts the HID descriptor before the endpoint.
module usb_desc_rom
  import usb_desc_pkg::*;
#(
  parameter logic [15:0] VID       = 16'h1209,
  parameter logic [15:0] PID       = 16'h0001,
  parameter logic [7:0]  EP0_MPS   = 8'd64,
  parameter logic [7:0]  MAX_POWER = 8'd50
) (
  input  logic [7:0]  desc_type,
  input  logic [5:0]  index,
  input  logic [7:0]  iface_class,
  input  logic [7:0]  iface_subclass,
  input  logic [7:0]  iface_protocol,
  input  logic [3:0]  ep_number,
  input  logic        ep_direction,
  input  logic [1:0]  ep_type,
  input  logic [10:0] ep_max_packet,
  input  logic [7:0]  ep_interval,
  input  logic [15:0] hid_report_len,
  output logic [7:0]  data
);

  logic [7:0] dev_b;
  logic [7:0] cfg_b;
  logic [5:0] rel;

`ifndef USB_DESC_HID_EN
  logic unused_hid;
  assign unused_hid = ^hid_report_len;
`endif

  always_comb begin
    dev_b = 8'h00;
    case (index)
      6'd0:  dev_b = {2'b00, DEV_LEN};
      6'd1:  dev_b = DESC_DEVICE;
      6'd3:  dev_b = 8'h02;
      6'd7:  dev_b = EP0_MPS;
      6'd8:  dev_b = VID[7:0];
      6'd9:  dev_b = VID[15:8];
      6'd10: dev_b = PID[7:0];
      6'd11: dev_b = PID[15:8];
      6'd13: dev_b = 8'h01;
      6'd17: dev_b = 8'h01;
      default: dev_b = 8'h00;
    endcase
  end

  always_comb begin
    cfg_b = 8'h00;
    rel   = 6'd0;
    if (index < CFG_LEN) begin
      case (index)
        6'd0: cfg_b = {2'b00, CFG_LEN};
        6'd1: cfg_b = DESC_CONFIGURATION;
        6'd2: cfg_b = {2'b00, CFG_TOTAL};
        6'd4: cfg_b = 8'h01;
        6'd5: cfg_b = 8'h01;
        6'd7: cfg_b = 8'h80;
        6'd8: cfg_b = MAX_POWER;
        default: cfg_b = 8'h00;
      endcase
    end else if (index < IF_END) begin
      rel = index - CFG_LEN;
      case (rel)
        6'd0: cfg_b = {2'b00, IF_LEN};
        6'd1: cfg_b = DESC_INTERFACE;
        6'd4: cfg_b = 8'h01;
        6'd5: cfg_b = iface_class;
        6'd6: cfg_b = iface_subclass;
        6'd7: cfg_b = iface_protocol;
        default: cfg_b = 8'h00;
      endcase
`ifdef USB_DESC_HID_EN
    end else if (index < EP_BASE) begin
      rel = index - IF_END;
      case (rel)
        6'd0: cfg_b = {2'b00, HID_LEN};
        6'd1: cfg_b = DESC_HID;
        6'd2: cfg_b = 8'h11;
        6'd3: cfg_b = 8'h01;
        6'd5: cfg_b = 8'h01;
        6'd6: cfg_b = 8'h22;
        6'd7: cfg_b = hid_report_len[7:0];
        6'd8: cfg_b = hid_report_len[15:8];
        default: cfg_b = 8'h00;
      endcase
`endif
    end else if (index < CFG_TOTAL) begin
      rel = index - EP_BASE;
      case (rel)
        6'd0: cfg_b = {2'b00, EP_LEN};
        6'd1: cfg_b = DESC_ENDPOINT;
        6'd2: cfg_b = {ep_direction, 3'b000, ep_number};
        6'd3: cfg_b = {6'b000000, ep_type};
        6'd4: cfg_b = ep_max_packet[7:0];
        6'd5: cfg_b = {5'b00000, ep_max_packet[10:8]};
        6'd6: cfg_b = ep_interval;
        default: cfg_b = 8'h00;
      endcase
    end
  end

  assign data = (desc_type == DESC_DEVICE) ? dev_b : cfg_b;

endmodule

// File: rtl/usb_descriptor_builder.sv
// GET_DESCRIPTOR streamer for Device/Configuration descriptors.
// USB_DESC_HID_EN adds a HID class descriptor (config total 34).
module usb_descriptor_builder
  import usb_desc_pkg::*;
#(
  parameter logic [15:0] VID       = 16'h1209,
  parameter logic [15:0] PID       = 16'h0001,
  parameter logic [7:0]  EP0_MPS   = 8'd64,
  parameter logic [7:0]  MAX_POWER = 8'd50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  req_type,
  input  logic [15:0] req_length,
  input  logic [7:0]  cfg_iface_class,
  input  logic [7:0]  cfg_iface_subclass,
  input  logic [7:0]  cfg_iface_protocol,
  input  logic [3:0]  cfg_ep_number,
  input  logic        cfg_ep_direction,
  input  logic [1:0]  cfg_ep_type,
  input  logic [10:0] cfg_ep_max_packet,
  input  logic [7:0]  cfg_ep_interval,
  input  logic [15:0] cfg_hid_report_len,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  state_t      state;
  logic [7:0]  sh_type;
  logic [15:0] sh_len;
  logic [7:0]  sh_class;
  logic [7:0]  sh_sub;
  logic [7:0]  sh_proto;
  logic [3:0]  sh_ep_num;
  logic        sh_ep_dir;
  logic [1:0]  sh_ep_type;
  logic [10:0] sh_ep_mps;
  logic [7:0]  sh_ep_int;
  logic [15:0] sh_hid_len;
  logic [5:0]  idx;
  logic [5:0]  count;

  logic [5:0]  total;
  logic [5:0]  load_count;
  logic [5:0]  rom_idx;
  logic [7:0]  rom_data;
  logic        accept;

  assign total = (sh_type == DESC_DEVICE) ? DEV_LEN : CFG_TOTAL;
  // Full 16-bit compare so large wLength values clamp to total.
  assign load_count = (sh_len < {10'd0, total}) ? sh_len[5:0] : total;
  assign rom_idx = (state == S_LOAD) ? 6'd0 : idx + 6'd1;
  assign accept = tx_valid && tx_ready;

  usb_desc_rom #(
    .VID       (VID),
    .PID       (PID),
    .EP0_MPS   (EP0_MPS),
    .MAX_POWER (MAX_POWER)
  ) u_rom (
    .desc_type      (sh_type),
    .index          (rom_idx),
    .iface_class    (sh_class),
    .iface_subclass (sh_sub),
    .iface_protocol (sh_proto),
    .ep_number      (sh_ep_num),
    .ep_direction   (sh_ep_dir),
    .ep_type        (sh_ep_type),
    .ep_max_packet  (sh_ep_mps),
    .ep_interval    (sh_ep_int),
    .hid_report_len (sh_hid_len),
    .data           (rom_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sh_type    <= 8'h00;
      sh_len     <= 16'h0000;
      sh_class   <= 8'h00;
      sh_sub     <= 8'h00;
      sh_proto   <= 8'h00;
      sh_ep_num  <= 4'h0;
      sh_ep_dir  <= 1'b0;
      sh_ep_type <= 2'b00;
      sh_ep_mps  <= 11'd0;
      sh_ep_int  <= 8'h00;
      sh_hid_len <= 16'h0000;
      idx        <= 6'd0;
      count      <= 6'd0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      tx_last    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      stall      <= 1'b0;
    end else begin
      done  <= 1'b0;
      stall <= 1'b0;
      if (abort) begin
        state    <= S_IDLE;
        tx_valid <= 1'b0;
        tx_last  <= 1'b0;
        busy     <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              sh_type    <= req_type;
              sh_len     <= req_length;
              sh_class   <= cfg_iface_class;
              sh_sub     <= cfg_iface_subclass;
              sh_proto   <= cfg_iface_protocol;
              sh_ep_num  <= cfg_ep_number;
              sh_ep_dir  <= cfg_ep_direction;
              sh_ep_type <= cfg_ep_type;
              sh_ep_mps  <= cfg_ep_max_packet;
              sh_ep_int  <= cfg_ep_interval;
              sh_hid_len <= cfg_hid_report_len;
              if (is_std_desc(req_type)) begin
                state <= S_LOAD;
                busy  <= 1'b1;
              end else begin
                stall <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            count <= load_count;
            idx   <= 6'd0;
            if (load_count == 6'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_SEND;
              tx_valid <= 1'b1;
              tx_data  <= rom_data;
              tx_last  <= (load_count == 6'd1);
            end
          end
          S_SEND: begin
            if (accept) begin
              if (tx_last) begin
                state    <= S_DONE;
                done     <= 1'b1;
                tx_valid <= 1'b0;
                tx_last  <= 1'b0;
              end else begin
                if (idx != total - 6'd1) idx <= idx + 6'd1;
                tx_data <= rom_data;
                tx_last <= (idx + 6'd2 == count);
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
